// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: operation encodings,
// CSR address map, mstatus bit positions and the read-only address test.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Addresses with [11:10] == 2'b11 are read-only by architecture.
    function automatic logic is_ro_addr(input logic [11:0] addr);
        return (addr >> 10) == 12'h3;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around counter with a software load port.
// A load in the same cycle as an increment wins; the increment is dropped.
module csr_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_val,
    input  logic            inc_en,
    output logic [XLEN-1:0] count
);

    // Load has priority over increment; the add wraps naturally at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_val;
        end else if (inc_en) begin
            count <= count + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file. Reads are combinational and return the pre-write
// value; writes, traps and mret commit at the rising edge. Trap and mret
// own mstatus/mepc/mcause in their cycle, so a CSR write to those three is
// dropped while either is active; writes to other CSRs still commit.
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              CSR_WIDTH = 2,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CSR_WIDTH-1:0] csr_op_i,
    input  logic [11:0]          addr_i,
    input  logic [XLEN-1:0]      data_i,
    input  logic                 instret_i,
    input  logic                 trap_i,
    input  logic [XLEN-1:0]      trap_pc_i,
    input  logic [XLEN-1:0]      trap_cause_i,
    input  logic                 mret_i,
    output logic [XLEN-1:0]      csr_data_o,
    output logic                 illegal_o,
    output logic [XLEN-1:0]      trap_vec_o,
    output logic [XLEN-1:0]      mepc_o
);

    csr_op_e         op;
    logic            access;
    logic            wr;
    logic            mapped;
    logic            wr_ok;
    logic            sys_evt;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mstatus_rd;

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:2] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:1] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    assign op      = csr_op_e'(csr_op_i[1:0]);
    assign access  = (op != CSR_NONE);
    assign wr      = (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (data_i != '0));
    assign sys_evt = trap_i | mret_i;

    // Only MIE and MPIE exist in mstatus; every other bit reads zero.
    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[MSTATUS_MIE]  = mie_q;
        mstatus_rd[MSTATUS_MPIE] = mpie_q;
    end

    // Address decode and read mux; unmapped addresses read zero.
    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (addr_i)
            CSR_MSTATUS:               old_val = mstatus_rd;
            CSR_MTVEC:                 old_val = {mtvec_q, 2'b00};
            CSR_MSCRATCH:              old_val = mscratch_q;
            CSR_MEPC:                  old_val = {mepc_q, 1'b0};
            CSR_MCAUSE:                old_val = mcause_q;
            CSR_MCYCLE, CSR_CYCLE:     old_val = mcycle;
            CSR_MINSTRET, CSR_INSTRET: old_val = minstret;
            default:                   mapped  = 1'b0;
        endcase
    end

    // New value for the read-modify-write operations.
    always_comb begin
        new_val = data_i;
        case (op)
            CSR_RS:  new_val = old_val | data_i;
            CSR_RC:  new_val = old_val & ~data_i;
            default: new_val = data_i;
        endcase
    end

    assign illegal_o  = access && (!mapped || (wr && is_ro_addr(addr_i)));
    assign wr_ok      = wr && !illegal_o;
    assign csr_data_o = old_val;
    assign trap_vec_o = {mtvec_q, 2'b00};
    assign mepc_o     = {mepc_q, 1'b0};

    // mstatus: trap stacks MIE into MPIE, mret unstacks, then software writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_i) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_ok && (addr_i == CSR_MSTATUS)) begin
            mie_q  <= new_val[MSTATUS_MIE];
            mpie_q <= new_val[MSTATUS_MPIE];
        end
    end

    // mepc/mcause: trap capture beats software; mret also blocks software writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i[XLEN-1:1];
            mcause_q <= trap_cause_i;
        end else if (wr_ok && !sys_evt) begin
            if (addr_i == CSR_MEPC)   mepc_q   <= new_val[XLEN-1:1];
            if (addr_i == CSR_MCAUSE) mcause_q <= new_val;
        end
    end

    // mtvec and mscratch are plain software-written registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtvec_q    <= RESET_VEC[XLEN-1:2];
            mscratch_q <= '0;
        end else if (wr_ok) begin
            if (addr_i == CSR_MTVEC)    mtvec_q    <= new_val[XLEN-1:2];
            if (addr_i == CSR_MSCRATCH) mscratch_q <= new_val;
        end
    end

    csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_en  (wr_ok && (addr_i == CSR_MCYCLE)),
        .load_val (new_val),
        .inc_en   (1'b1),
        .count    (mcycle)
    );

    csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_en  (wr_ok && (addr_i == CSR_MINSTRET)),
        .load_val (new_val),
        .inc_en   (instret_i),
        .count    (minstret)
    );

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file. The stimulus process drives one access per
// cycle and queues the hand-computed responses; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_csr_file;

   localparam int          XLEN   = 64;
   localparam logic [63:0] RVEC   = 64'h8000_0103;
   localparam logic [63:0] RVEC_M = 64'h8000_0100;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

   localparam int SEL_DATA = 0;
   localparam int SEL_ILL  = 1;
   localparam int SEL_TVEC = 2;
   localparam int SEL_MEPC = 3;

   logic            clk;
   logic            rst;
   logic [1:0]      csr_op;
   logic [11:0]     addr;
   logic [XLEN-1:0] data;
   logic            instret;
   logic            trap;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] trap_cause;
   logic            mret;
   logic [XLEN-1:0] csr_data;
   logic            illegal;
   logic [XLEN-1:0] trap_vec;
   logic [XLEN-1:0] mepc;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   csr_file #(.XLEN(XLEN), .CSR_WIDTH(2), .RESET_VEC(RVEC)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .csr_op_i     (csr_op),
      .addr_i       (addr),
      .data_i       (data),
      .instret_i    (instret),
      .trap_i       (trap),
      .trap_pc_i    (trap_pc),
      .trap_cause_i (trap_cause),
      .mret_i       (mret),
      .csr_data_o   (csr_data),
      .illegal_o    (illegal),
      .trap_vec_o   (trap_vec),
      .mepc_o       (mepc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
      step();
      csr_op     = op;
      addr       = a;
      data       = d;
      instret    = 1'b0;
      trap       = 1'b0;
      trap_pc    = '0;
      trap_cause = '0;
      mret       = 1'b0;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [63:0] act;
         e = sb.pop_front();
         case (e.sel)
            SEL_DATA: act = csr_data;
            SEL_ILL:  act = {63'd0, illegal};
            SEL_TVEC: act = trap_vec;
            default:  act = mepc;
         endcase
         n_checks++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      csr_op     = 2'd0;
      addr       = 12'h340;
      data       = '0;
      instret    = 1'b0;
      trap       = 1'b0;
      trap_pc    = '0;
      trap_cause = '0;
      mret       = 1'b0;
      #1;
      n_checks++;
      if (trap_vec !== RVEC_M) begin
         n_fail++;
         $display("FAIL rst_trap_vec_direct: got %h expected %h", trap_vec, RVEC_M);
      end
      n_checks++;
      if (mepc !== 64'd0) begin
         n_fail++;
         $display("FAIL rst_mepc_direct: got %h expected %h", mepc, 64'd0);
      end
      expect_val("rst_trap_vec", SEL_TVEC, RVEC_M);
      expect_val("rst_mepc", SEL_MEPC, 64'd0);
      expect_val("rst_mscratch", SEL_DATA, 64'd0);
      expect_val("rst_illegal", SEL_ILL, 64'd0);

      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      csr_op = 2'd2; addr = 12'hC00; data = '0;
      expect_val("cycle_after_reset", SEL_DATA, 64'd5);
      expect_val("cycle_rs0_legal", SEL_ILL, 64'd0);
      expect_val("trap_vec_reset", SEL_TVEC, RVEC_M);

      cyc(2'd0, 12'h305, 64'd0);
      expect_val("mtvec_read_reset", SEL_DATA, RVEC_M);
      expect_val("mepc_out_reset", SEL_MEPC, 64'd0);

      cyc(2'd1, 12'h340, 64'hDEAD_BEEF);
      expect_val("mscratch_pre_rw", SEL_DATA, 64'd0);
      cyc(2'd2, 12'h340, 64'hF0);
      expect_val("mscratch_after_rw", SEL_DATA, 64'hDEAD_BEEF);
      cyc(2'd3, 12'h340, 64'h0F);
      expect_val("mscratch_after_rs", SEL_DATA, 64'hDEAD_BEFF);
      cyc(2'd0, 12'h340, 64'd0);
      expect_val("mscratch_after_rc", SEL_DATA, 64'hDEAD_BEF0);

      cyc(2'd1, 12'hC02, 64'd5);
      expect_val("instret_rw_illegal", SEL_ILL, 64'd1);
      expect_val("instret_rw_read", SEL_DATA, 64'd0);
      cyc(2'd0, 12'hB02, 64'd0);
      expect_val("minstret_unchanged", SEL_DATA, 64'd0);
      expect_val("none_legal", SEL_ILL, 64'd0);
      cyc(2'd2, 12'hC00, 64'd0);
      expect_val("cycle_rs0_legal2", SEL_ILL, 64'd0);
      expect_val("cycle_count_mid", SEL_DATA, 64'd13);
      cyc(2'd1, 12'h123, 64'hFF);
      expect_val("unmapped_illegal", SEL_ILL, 64'd1);
      expect_val("unmapped_reads0", SEL_DATA, 64'd0);
      cyc(2'd0, 12'h123, 64'd0);
      expect_val("unmapped_none_legal", SEL_ILL, 64'd0);

      for (int i = 0; i < 3; i++) begin
         cyc(2'd0, 12'h000, 64'd0);
         instret = 1'b1;
      end
      cyc(2'd0, 12'hC02, 64'd0);
      expect_val("instret_count", SEL_DATA, 64'd3);

      cyc(2'd1, 12'h300, ONES);
      expect_val("mstatus_reset", SEL_DATA, 64'd0);
      cyc(2'd0, 12'h300, 64'd0);
      expect_val("mstatus_masked", SEL_DATA, 64'h88);
      cyc(2'd0, 12'h000, 64'd0);
      trap = 1'b1; trap_pc = 64'h1001; trap_cause = 64'd11;
      cyc(2'd0, 12'h341, 64'd0);
      expect_val("mepc_after_trap", SEL_DATA, 64'h1000);
      expect_val("mepc_out_trap", SEL_MEPC, 64'h1000);
      cyc(2'd0, 12'h342, 64'd0);
      expect_val("mcause_after_trap", SEL_DATA, 64'd11);
      cyc(2'd0, 12'h300, 64'd0);
      mret = 1'b1;
      expect_val("mstatus_after_trap", SEL_DATA, 64'h80);
      cyc(2'd0, 12'h300, 64'd0);
      expect_val("mstatus_after_mret", SEL_DATA, 64'h88);

      cyc(2'd1, 12'h341, 64'h40);
      trap = 1'b1; trap_pc = 64'h2000; trap_cause = 64'd2;
      cyc(2'd0, 12'h341, 64'd0);
      expect_val("trap_beats_write", SEL_DATA, 64'h2000);
      expect_val("mepc_out_trap2", SEL_MEPC, 64'h2000);
      cyc(2'd0, 12'h300, 64'd0);
      expect_val("mstatus_trap2", SEL_DATA, 64'h80);
      cyc(2'd0, 12'h342, 64'd0);
      expect_val("mcause_trap2", SEL_DATA, 64'd2);

      cyc(2'd1, 12'h341, 64'h43);
      cyc(2'd0, 12'h341, 64'd0);
      expect_val("mepc_bit0_masked", SEL_DATA, 64'h42);
      expect_val("mepc_out_sw", SEL_MEPC, 64'h42);
      cyc(2'd1, 12'h305, 64'h207);
      cyc(2'd0, 12'h305, 64'd0);
      expect_val("mtvec_masked", SEL_DATA, 64'h204);
      expect_val("trap_vec_sw", SEL_TVEC, 64'h204);

      cyc(2'd1, 12'hB00, ONES);
      cyc(2'd0, 12'hB00, 64'd0);
      expect_val("mcycle_write_beats_inc", SEL_DATA, ONES);
      cyc(2'd0, 12'hC00, 64'd0);
      expect_val("mcycle_wrap", SEL_DATA, 64'd0);

      cyc(2'd1, 12'h340, 64'h1234);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (mepc !== 64'd0) begin
         n_fail++;
         $display("FAIL async_rst_mepc_direct: got %h expected %h", mepc, 64'd0);
      end
      expect_val("async_rst_mscratch", SEL_DATA, 64'd0);
      expect_val("async_rst_mepc", SEL_MEPC, 64'd0);
      expect_val("async_rst_trap_vec", SEL_TVEC, RVEC_M);
      step();
      rst = 1'b0; csr_op = 2'd0; addr = 12'h340; data = '0;
      expect_val("write_lost_in_reset", SEL_DATA, 64'd0);
      cyc(2'd0, 12'hB00, 64'd0);
      expect_val("mcycle_first_edge", SEL_DATA, 64'd1);
      cyc(2'd0, 12'h300, 64'd0);
      expect_val("mstatus_after_rst", SEL_DATA, 64'd0);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
